// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared ALU with a one-deep response slot
// and an architectural NZCV flag register.
// Optional feature: define ALU_ARB_ROUND_ROBIN_EN for round-robin arbitration
// (default build: requester 0 has fixed priority and no last-grant pointer).
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             Reset,

    input  logic             Req0_Valid,
    output logic             Req0_Ready,
    input  logic [1:0]       Req0_Op,
    input  logic [WIDTH-1:0] Req0_A,
    input  logic [WIDTH-1:0] Req0_B,
    input  logic             Req0_S,

    input  logic             Req1_Valid,
    output logic             Req1_Ready,
    input  logic [1:0]       Req1_Op,
    input  logic [WIDTH-1:0] Req1_A,
    input  logic [WIDTH-1:0] Req1_B,
    input  logic             Req1_S,

    output logic [WIDTH-1:0] ALU_SrcA,
    output logic [WIDTH-1:0] ALU_SrcB,
    output logic [1:0]       ALU_Control,
    input  logic [WIDTH-1:0] ALU_Result,
    input  logic [3:0]       ALU_Flags,

    output logic             Rsp_Valid,
    input  logic             Rsp_Ready,
    output logic             Rsp_Id,
    output logic [WIDTH-1:0] Rsp_Result,
    output logic [3:0]       Rsp_Flags,

    output logic [3:0]       Flags_Q
);

    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic [3:0]       rsp_flags_q, rsp_flags_d;
    logic [3:0]       flags_q, flags_d;

    logic             slot_free_s;
    logic             grant0_s;
    logic             grant1_s;
    logic             accept_s;
    logic             accept_s_flag_s;

`ifdef ALU_ARB_ROUND_ROBIN_EN
    // 1 means requester 1 was granted last, so requester 0 wins the next tie.
    logic             last_grant_q, last_grant_d;
`endif

    // Grant selection: combinational, gated by a free response slot and reset.
    always_comb begin
        slot_free_s = ~rsp_valid_q | Rsp_Ready;
        grant0_s    = 1'b0;
        grant1_s    = 1'b0;
        if (Reset || !slot_free_s) begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end else if (Req0_Valid && Req1_Valid) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
            if (last_grant_q) begin
                grant0_s = 1'b1;
            end else begin
                grant1_s = 1'b1;
            end
`else
            grant0_s = 1'b1;
`endif
        end else if (Req0_Valid) begin
            grant0_s = 1'b1;
        end else if (Req1_Valid) begin
            grant1_s = 1'b1;
        end else begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
        end
    end

    // Shared ALU operand/control mux driven from the granted requester.
    always_comb begin
        ALU_SrcA        = {WIDTH{1'b0}};
        ALU_SrcB        = {WIDTH{1'b0}};
        ALU_Control     = 2'b00;
        accept_s_flag_s = 1'b0;
        if (grant0_s) begin
            ALU_SrcA        = Req0_A;
            ALU_SrcB        = Req0_B;
            ALU_Control     = Req0_Op;
            accept_s_flag_s = Req0_S;
        end else if (grant1_s) begin
            ALU_SrcA        = Req1_A;
            ALU_SrcB        = Req1_B;
            ALU_Control     = Req1_Op;
            accept_s_flag_s = Req1_S;
        end else begin
            ALU_SrcA        = {WIDTH{1'b0}};
            ALU_SrcB        = {WIDTH{1'b0}};
            ALU_Control     = 2'b00;
            accept_s_flag_s = 1'b0;
        end
    end

    assign accept_s   = grant0_s | grant1_s;
    assign Req0_Ready = grant0_s;
    assign Req1_Ready = grant1_s;

    // Response slot and flag register next state; an accept wins over a drain.
    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        flags_d      = flags_q;
        if (accept_s) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = grant1_s;
            rsp_result_d = ALU_Result;
            rsp_flags_d  = ALU_Flags;
            if (accept_s_flag_s) begin
                flags_d = ALU_Flags;
            end else begin
                flags_d = flags_q;
            end
        end else if (rsp_valid_q && Rsp_Ready) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
    end

`ifdef ALU_ARB_ROUND_ROBIN_EN
    // Last-grant pointer moves only when an operation is accepted.
    always_comb begin
        if (accept_s) begin
            last_grant_d = grant1_s;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Last-grant pointer register; reset favours requester 0.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    // Response slot and flag state registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= {WIDTH{1'b0}};
            rsp_flags_q  <= 4'b0000;
            flags_q      <= 4'b0000;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
            flags_q      <= flags_d;
        end
    end

    assign Rsp_Valid  = rsp_valid_q;
    assign Rsp_Id     = rsp_id_q;
    assign Rsp_Result = rsp_result_q;
    assign Rsp_Flags  = rsp_flags_q;
    assign Flags_Q    = flags_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width (only 32 is supported).
REQ-002 SHALL have port: CLK  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port: Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports: Req0_Valid / Req1_Valid  input  1  requester n has an operation pending.
REQ-005 SHALL have ports: Req0_Ready / Req1_Ready  output  1  requester n's operation is accepted this cycle.
REQ-006 SHALL have ports: Req0_Op / Req1_Op  input  2  ALU operation: 00 ADD, 01 SUB, 10 AND, 11 ORR.
REQ-007 SHALL have ports: Req0_A, Req0_B / Req1_A, Req1_B  input  32  operands.
REQ-008 SHALL have ports: Req0_S / Req1_S  input  1  the operation updates the flag register.
REQ-009 SHALL have ports: ALU_SrcA, ALU_SrcB  output  32  and ALU_Control  output  2  drive to the shared external ALU.
REQ-010 SHALL have ports: ALU_Result  input  32  and ALU_Flags  input  4  {N,Z,C,V} returned by the ALU in the same cycle.
REQ-011 SHALL have ports: Rsp_Valid  output  1, Rsp_Ready  input  1, Rsp_Id  output  1 (requester index), Rsp_Result  output  32, Rsp_Flags  output  4.
REQ-012 SHALL have port: Flags_Q  output  4  architectural NZCV register.

Function
REQ-013 SHALL define the response slot as free when Rsp_Valid=0 or Rsp_Ready=1.
REQ-014 SHALL assert at most one of Req0_Ready/Req1_Ready per cycle, only when the slot is free and the granted Reqn_Valid=1.
REQ-015 SHALL select the grant combinationally; a single valid requester is always granted when the slot is free.
REQ-016 SHALL drive ALU_SrcA/ALU_SrcB/ALU_Control from the granted requester in the same cycle; with no grant, SHALL drive 0/0/00.
REQ-017 On accept (Reqn_Valid & Reqn_Ready) SHALL register ALU_Result->Rsp_Result, ALU_Flags->Rsp_Flags, n->Rsp_Id and set Rsp_Valid; latency SHALL be exactly 1 cycle.
REQ-018 SHALL clear Rsp_Valid on Rsp_Valid & Rsp_Ready with no simultaneous accept; accept plus drain in one cycle SHALL reload the slot (back-to-back, full throughput).
REQ-019 SHALL hold Rsp_Result/Rsp_Flags/Rsp_Id stable while Rsp_Valid=1 and Rsp_Ready=0.
REQ-020 SHALL load Flags_Q with ALU_Flags on the accept edge iff the accepted Reqn_S=1; otherwise Flags_Q SHALL hold.
REQ-021 SHALL keep a last-grant pointer updated only on accept; the pointer SHALL NOT change on stalled or idle cycles.
REQ-022 Requester inputs SHALL be ignored in any cycle where they are not accepted (no internal request queue).

Reset
REQ-023 On Reset=1 at a rising edge: Rsp_Valid=0, Rsp_Id=0, Rsp_Result=0, Rsp_Flags=0, Flags_Q=0, and last-grant=1 (port 0 favoured next).
REQ-024 Reset SHALL override any simultaneous accept or drain; an in-flight response SHALL be discarded, and Flags_Q SHALL NOT take that cycle's ALU_Flags.
REQ-025 Req0_Ready/Req1_Ready SHALL be 0 in any cycle where Reset=1.

Configuration
REQ-026 With macro ALU_ARB_ROUND_ROBIN_EN defined, the requester not indicated by last-grant SHALL win when both requesters are valid.
REQ-027 Without ALU_ARB_ROUND_ROBIN_EN, requester 0 SHALL always win when both are valid, and the last-grant pointer SHALL be omitted.

Verification
REQ-028 Single op: Req0 ADD A=0x7FFFFFFF, B=1, S=1, Rsp_Ready=1 -> next cycle Rsp_Valid=1, Rsp_Id=0, Rsp_Result=0x80000000, Rsp_Flags=Flags_Q=4'b1001.
REQ-029 Contention, both valid for 4 cycles, Rsp_Ready=1 -> grants 0,1,0,1 with _EN; 0,0,0,0 without.
REQ-030 Backpressure: Req1 SUB 5-5, S=0, Rsp_Ready=0 for 3 cycles -> Rsp_Valid held with Result 0 and Flags 4'b0110; Req Ready=0 for both ports; Flags_Q unchanged; drains on first Rsp_Ready=1 cycle.
REQ-031 Back-to-back: Req0 ORR 0xF0|0x0F, then Req0 AND 0xF0&0x0F on consecutive cycles, Rsp_Ready=1 -> Rsp_Result 0x000000FF then 0x00000000, no bubble.
REQ-032 Reset mid-operation: assert Reset on the accept cycle of Req0 SUB 0-1, S=1 -> next cycle Rsp_Valid=0, Flags_Q=0, and the next contention grants port 0.
